// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle MIPS controller
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPEEX  = 4'd6,
    RTYPEWB  = 4'd7,
    BEQEX    = 4'd8,
    BNEEX    = 4'd9,
    IMMEX    = 4'd10,
    IMMWB    = 4'd11,
    JEX      = 4'd12,
    TRAP     = 4'd13
  } mc_state_t;

  // Which flavour of ALU operation the current state asks for
  typedef enum logic [2:0] {
    ACLS_NONE  = 3'd0,
    ACLS_ADD   = 3'd1,
    ACLS_SUB   = 3'd2,
    ACLS_FUNCT = 3'd3,
    ACLS_IMM   = 3'd4
  } mc_alucls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Logical immediates take a zero-extended operand
  function automatic logic is_zext_op(input logic [5:0] op_in);
    return (op_in == OP_ANDI) || (op_in == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - maps state class, opcode and funct to the ALU control code
module mc_aludec
  import mc_pkg::*;
(
  input  logic [2:0] i_cls,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  // Pick the ALU operation; unknown funct/op fall back to ADD rather than trapping
  always_comb begin
    o_alucontrol = 3'b000;
    case (i_cls)
      ACLS_ADD: o_alucontrol = ALU_ADD;
      ACLS_SUB: o_alucontrol = ALU_SUB;
      ACLS_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alucontrol = ALU_ADD;
          FN_SUB:  o_alucontrol = ALU_SUB;
          FN_AND:  o_alucontrol = ALU_AND;
          FN_OR:   o_alucontrol = ALU_OR;
          FN_SLT:  o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      ACLS_IMM: begin
        case (i_op)
          OP_ANDI: o_alucontrol = ALU_AND;
          OP_ORI:  o_alucontrol = ALU_OR;
          OP_SLTI: o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_controller_p.sv
// rtl/mc_controller_p.sv - multicycle MIPS control FSM with memory handshake and retire counter
module mc_controller_p
  import mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             zeroext,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  mc_state_t        r_state;
  logic [CNT_W-1:0] r_instret;
  logic             r_illegal;

  logic       w_ready;
  logic       w_pcen_raw;
  logic       w_irwrite_raw;
  mc_alucls_t w_alucls;

  // Without the handshake every memory access completes in one cycle
  assign w_ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  // State register, sticky trap flag and retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ready) r_state <= DECODE;
        end
        DECODE: begin
          case (op)
            OP_LW, OP_SW:                     r_state <= MEMADR;
            OP_RTYPE:                         r_state <= RTYPEEX;
            OP_BEQ:                           r_state <= BEQEX;
            OP_BNE:                           r_state <= BNEEX;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: r_state <= IMMEX;
            OP_J:                             r_state <= JEX;
            default: begin
              r_state   <= TRAP;
              r_illegal <= 1'b1;
            end
          endcase
        end
        MEMADR: begin
          r_state <= (op == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          if (w_ready) r_state <= MEMWB;
        end
        MEMWR: begin
          if (w_ready) begin
            r_state   <= FETCH;
            r_instret <= r_instret + CNT_W'(1);
          end
        end
        RTYPEEX: r_state <= RTYPEWB;
        IMMEX:   r_state <= IMMWB;
        MEMWB, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX: begin
          r_state   <= FETCH;
          r_instret <= r_instret + CNT_W'(1);
        end
        TRAP: begin
          r_state   <= TRAP;
          r_illegal <= 1'b1;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // Moore output decode; only the fetch enables and branch enable look at live inputs
  always_comb begin
    mem_req       = 1'b0;
    w_pcen_raw    = 1'b0;
    memwrite      = 1'b0;
    w_irwrite_raw = 1'b0;
    regwrite      = 1'b0;
    alusrca       = 1'b0;
    iord          = 1'b0;
    memtoreg      = 1'b0;
    regdst        = 1'b0;
    zeroext       = 1'b0;
    alusrcb       = 2'b00;
    pcsrc         = 2'b00;
    w_alucls      = ACLS_NONE;
    case (r_state)
      FETCH: begin
        mem_req       = 1'b1;
        alusrcb       = 2'b01;
        w_alucls      = ACLS_ADD;
        w_irwrite_raw = w_ready;
        w_pcen_raw    = w_ready;
      end
      DECODE: begin
        alusrcb  = 2'b11;
        w_alucls = ACLS_ADD;
      end
      MEMADR: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        w_alucls = ACLS_ADD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      RTYPEEX: begin
        alusrca  = 1'b1;
        w_alucls = ACLS_FUNCT;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        w_alucls   = ACLS_SUB;
        pcsrc      = 2'b01;
        w_pcen_raw = zero;
      end
      BNEEX: begin
        alusrca    = 1'b1;
        w_alucls   = ACLS_SUB;
        pcsrc      = 2'b01;
        w_pcen_raw = ~zero;
      end
      IMMEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        w_alucls = ACLS_IMM;
        zeroext  = is_zext_op(op);
      end
      IMMWB: begin
        regwrite = 1'b1;
        w_alucls = ACLS_IMM;
        zeroext  = is_zext_op(op);
      end
      JEX: begin
        w_pcen_raw = 1'b1;
        pcsrc      = 2'b10;
      end
      default: begin
        w_alucls = ACLS_NONE;
      end
    endcase
  end

  // Enables are masked while reset is held so nothing is written during reset
  assign pcen    = w_pcen_raw & ~reset;
  assign irwrite = w_irwrite_raw & ~reset;
  assign illegal = r_illegal;
  assign instret = r_instret;

  mc_aludec u_aludec (
    .i_cls        (w_alucls),
    .i_op         (op),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller_p.sv
// tb/tb_mc_controller_p.sv - directed self-checking bench for mc_controller_p
module tb_mc_controller_p;

  // Output signature order:
  // mem_req pcen memwrite irwrite regwrite alusrca iord memtoreg regdst zeroext alusrcb pcsrc alucontrol illegal
  localparam logic [17:0] S_FETCH_RDY  = 18'b1_1_0_1_0_0_0_0_0_0_01_00_010_0;
  localparam logic [17:0] S_FETCH_WAIT = 18'b1_0_0_0_0_0_0_0_0_0_01_00_010_0;
  localparam logic [17:0] S_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_11_00_010_0;
  localparam logic [17:0] S_MEMADR     = 18'b0_0_0_0_0_1_0_0_0_0_10_00_010_0;
  localparam logic [17:0] S_MEMRD      = 18'b1_0_0_0_0_0_1_0_0_0_00_00_000_0;
  localparam logic [17:0] S_MEMWR      = 18'b1_0_1_0_0_0_1_0_0_0_00_00_000_0;
  localparam logic [17:0] S_MEMWB      = 18'b0_0_0_0_1_0_0_1_0_0_00_00_000_0;
  localparam logic [17:0] S_RTEX_SUB   = 18'b0_0_0_0_0_1_0_0_0_0_00_00_110_0;
  localparam logic [17:0] S_RTWB       = 18'b0_0_0_0_1_0_0_0_1_0_00_00_000_0;
  localparam logic [17:0] S_BR_TAKEN   = 18'b0_1_0_0_0_1_0_0_0_0_00_01_110_0;
  localparam logic [17:0] S_BR_NOT     = 18'b0_0_0_0_0_1_0_0_0_0_00_01_110_0;
  localparam logic [17:0] S_ORI_EX     = 18'b0_0_0_0_0_1_0_0_0_1_10_00_001_0;
  localparam logic [17:0] S_ORI_WB     = 18'b0_0_0_0_1_0_0_0_0_1_00_00_001_0;
  localparam logic [17:0] S_JEX        = 18'b0_1_0_0_0_0_0_0_0_0_00_10_000_0;
  localparam logic [17:0] S_TRAP       = 18'b0_0_0_0_0_0_0_0_0_0_00_00_000_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset_c;
  logic [5:0] op, funct;
  logic       zero, mem_ready, mem_ready_n;

  logic        mem_req_a, pcen_a, memwrite_a, irwrite_a, regwrite_a, alusrca_a, iord_a;
  logic        memtoreg_a, regdst_a, zeroext_a, illegal_a;
  logic [1:0]  alusrcb_a, pcsrc_a;
  logic [2:0]  alucontrol_a;
  logic [31:0] instret_a;

  logic        mem_req_w, pcen_w, memwrite_w, irwrite_w, regwrite_w, alusrca_w, iord_w;
  logic        memtoreg_w, regdst_w, zeroext_w, illegal_w;
  logic [1:0]  alusrcb_w, pcsrc_w;
  logic [2:0]  alucontrol_w;
  logic [3:0]  instret_w;

  logic        mem_req_n, pcen_n, memwrite_n, irwrite_n, regwrite_n, alusrca_n, iord_n;
  logic        memtoreg_n, regdst_n, zeroext_n, illegal_n;
  logic [1:0]  alusrcb_n, pcsrc_n;
  logic [2:0]  alucontrol_n;
  logic [3:0]  instret_n;

  logic [17:0] sig_a, sig_w, sig_n;
  assign sig_a = {mem_req_a, pcen_a, memwrite_a, irwrite_a, regwrite_a, alusrca_a, iord_a,
                  memtoreg_a, regdst_a, zeroext_a, alusrcb_a, pcsrc_a, alucontrol_a, illegal_a};
  assign sig_w = {mem_req_w, pcen_w, memwrite_w, irwrite_w, regwrite_w, alusrca_w, iord_w,
                  memtoreg_w, regdst_w, zeroext_w, alusrcb_w, pcsrc_w, alucontrol_w, illegal_w};
  assign sig_n = {mem_req_n, pcen_n, memwrite_n, irwrite_n, regwrite_n, alusrca_n, iord_n,
                  memtoreg_n, regdst_n, zeroext_n, alusrcb_n, pcsrc_n, alucontrol_n, illegal_n};

  mc_controller_p dut_a (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_a), .pcen(pcen_a), .memwrite(memwrite_a), .irwrite(irwrite_a),
    .regwrite(regwrite_a), .alusrca(alusrca_a), .iord(iord_a), .memtoreg(memtoreg_a),
    .regdst(regdst_a), .zeroext(zeroext_a), .alusrcb(alusrcb_a), .pcsrc(pcsrc_a),
    .alucontrol(alucontrol_a), .illegal(illegal_a), .instret(instret_a)
  );

  mc_controller_p #(.MEM_HANDSHAKE(1), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset_c), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_w), .pcen(pcen_w), .memwrite(memwrite_w), .irwrite(irwrite_w),
    .regwrite(regwrite_w), .alusrca(alusrca_w), .iord(iord_w), .memtoreg(memtoreg_w),
    .regdst(regdst_w), .zeroext(zeroext_w), .alusrcb(alusrcb_w), .pcsrc(pcsrc_w),
    .alucontrol(alucontrol_w), .illegal(illegal_w), .instret(instret_w)
  );

  mc_controller_p #(.MEM_HANDSHAKE(0), .CNT_W(4)) dut_n (
    .clk(clk), .reset(reset_c), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready_n),
    .mem_req(mem_req_n), .pcen(pcen_n), .memwrite(memwrite_n), .irwrite(irwrite_n),
    .regwrite(regwrite_n), .alusrca(alusrca_n), .iord(iord_n), .memtoreg(memtoreg_n),
    .regdst(regdst_n), .zeroext(zeroext_n), .alusrcb(alusrcb_n), .pcsrc(pcsrc_n),
    .alucontrol(alucontrol_n), .illegal(illegal_n), .instret(instret_n)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the main DUT's outputs in the current state, then advance one clock
  task automatic stp(input string tag, input logic [17:0] exp);
    #1;
    chk(tag, 32'(sig_a), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    reset_c     = 1'b1;
    op          = 6'b000000;
    funct       = 6'b000000;
    zero        = 1'b0;
    mem_ready   = 1'b1;
    mem_ready_n = 1'b0;

    #2;
    chk("rst_sig", 32'(sig_a), 32'(S_FETCH_WAIT));
    chk("rst_instret", instret_a, 32'd0);
    chk("rst_illegal", 32'(illegal_a), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    op = 6'b100011;
    stp("lw_fetch", S_FETCH_RDY);
    stp("lw_decode", S_DECODE);
    stp("lw_memadr", S_MEMADR);
    stp("lw_memrd", S_MEMRD);
    stp("lw_memwb", S_MEMWB);
    chk("lw_instret", instret_a, 32'd1);

    op = 6'b000000;
    funct = 6'b100010;
    stp("sub_fetch", S_FETCH_RDY);
    stp("sub_decode", S_DECODE);
    stp("sub_rtex", S_RTEX_SUB);
    stp("sub_rtwb", S_RTWB);
    chk("sub_instret", instret_a, 32'd2);

    op = 6'b101011;
    stp("sw_fetch", S_FETCH_RDY);
    stp("sw_decode", S_DECODE);
    stp("sw_memadr", S_MEMADR);
    mem_ready = 1'b0;
    stp("sw_wait0", S_MEMWR);
    stp("sw_wait1", S_MEMWR);
    stp("sw_wait2", S_MEMWR);
    mem_ready = 1'b1;
    stp("sw_done", S_MEMWR);
    chk("sw_instret", instret_a, 32'd3);

    mem_ready = 1'b0;
    stp("fetch_wait", S_FETCH_WAIT);
    mem_ready = 1'b1;

    op = 6'b000100;
    zero = 1'b1;
    stp("beq_fetch", S_FETCH_RDY);
    stp("beq_decode", S_DECODE);
    stp("beq_z1", S_BR_TAKEN);

    op = 6'b000101;
    stp("bne1_fetch", S_FETCH_RDY);
    stp("bne1_decode", S_DECODE);
    stp("bne_z1", S_BR_NOT);

    zero = 1'b0;
    stp("bne0_fetch", S_FETCH_RDY);
    stp("bne0_decode", S_DECODE);
    stp("bne_z0", S_BR_TAKEN);

    op = 6'b001101;
    stp("ori_fetch", S_FETCH_RDY);
    stp("ori_decode", S_DECODE);
    stp("ori_ex", S_ORI_EX);
    stp("ori_wb", S_ORI_WB);
    chk("ori_instret", instret_a, 32'd7);

    op = 6'b111111;
    stp("ill_fetch", S_FETCH_RDY);
    stp("ill_decode", S_DECODE);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      zero = i[1];
      stp("trap_hold", S_TRAP);
    end
    chk("trap_instret", instret_a, 32'd7);

    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_illegal", 32'(illegal_a), 32'd0);
    chk("mid_rst_instret", instret_a, 32'd0);
    chk("mid_rst_sig", 32'(sig_a), 32'(S_FETCH_WAIT));
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    op = 6'b000010;
    stp("post_rst_fetch", S_FETCH_RDY);
    stp("post_rst_decode", S_DECODE);
    stp("post_rst_jex", S_JEX);
    chk("post_rst_instret", instret_a, 32'd1);

    reset_c = 1'b0;
    op = 6'b000010;
    mem_ready = 1'b1;
    mem_ready_n = 1'b0;
    for (int k = 0; k < 17; k++) begin
      #1;
      chk("wrap_w_fetch", 32'(sig_w), 32'(S_FETCH_RDY));
      chk("nohs_fetch", 32'(sig_n), 32'(S_FETCH_RDY));
      @(posedge clk);
      #1;
      chk("wrap_w_decode", 32'(sig_w), 32'(S_DECODE));
      chk("nohs_decode", 32'(sig_n), 32'(S_DECODE));
      @(posedge clk);
      #1;
      chk("wrap_w_jex", 32'(sig_w), 32'(S_JEX));
      chk("nohs_jex", 32'(sig_n), 32'(S_JEX));
      @(posedge clk);
      #1;
      if (k == 15) begin
        chk("wrap_w_16", 32'(instret_w), 32'd0);
        chk("nohs_16", 32'(instret_n), 32'd0);
      end
    end
    chk("wrap_w_17", 32'(instret_w), 32'd1);
    chk("nohs_17", 32'(instret_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller_p.md
# mc_controller_p

Parametrised multicycle MIPS control unit: the next generation of the team's multicycle controller FSM. It adds:
- a memory request/ready handshake with wait states,
- BNE, ORI and SLTI,
- internal PC-enable generation from `zero`,
- a zero/sign-extend select,
- a sticky illegal-opcode trap,
- a retired-instruction counter.

It sits between the instruction register and the multicycle datapath/memory.

## Interface
**Parameters**
- `MEM_HANDSHAKE`, default 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- `CNT_W`, default 32: width of `instret`.

**Ports** (one clock; reset is asynchronous and active-high)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `op`  in  6  instruction opcode field
- `funct`  in  6  R-type funct field
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access active
- `pcen`  out  1  PC register write enable (unconditional or taken branch)
- `memwrite`  out  1  memory write
- `irwrite`  out  1  instruction register write
- `regwrite`  out  1  register file write
- `alusrca`  out  1  0 = PC, 1 = A
- `iord`  out  1  0 = PC address, 1 = ALUOut address
- `memtoreg`  out  1  1 = write-back from data register
- `regdst`  out  1  1 = rd, 0 = rt
- `zeroext`  out  1  1 = zero-extend immediate (ANDI/ORI)
- `alusrcb`  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- `pcsrc`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- `alucontrol`  out  3  010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT
- `illegal`  out  1  sticky trap flag
- `instret`  out  `CNT_W`  retired-instruction count

## Operation
**States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, IMMEX, IMMWB, JEX, TRAP.

**Transitions**
- FETCH → DECODE when `mem_ready`; otherwise hold.
- DECODE dispatches on `op`:
  - 100011 (LW) / 101011 (SW) → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 000101 → BNEEX
  - 001000 (ADDI), 001100 (ANDI), 001101 (ORI), 001010 (SLTI) → IMMEX
  - 000010 → JEX
  - anything else → TRAP
- MEMADR → MEMRD (LW) or MEMWR (SW).
- MEMRD → MEMWB when `mem_ready`; otherwise hold.
- MEMWR → FETCH when `mem_ready`; otherwise hold.
- MEMWB, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX → FETCH.
- RTYPEEX → RTYPEWB; IMMEX → IMMWB.
- TRAP holds until reset.

**Outputs** (any output not listed is 0)
- FETCH: `mem_req`=1, `alusrcb`=01, ADD; `irwrite` and `pcen` are 1 only in the `mem_ready` cycle.
- DECODE: `alusrcb`=11, ADD.
- MEMADR: `alusrca`=1, `alusrcb`=10, ADD.
- MEMRD: `mem_req`=1, `iord`=1.
- MEMWR: `mem_req`=1, `iord`=1; `memwrite` is 1 throughout the state.
- MEMWB: `regwrite`=1, `memtoreg`=1.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `alucontrol` decoded from `funct`.
- RTYPEWB: `regwrite`=1, `regdst`=1.
- BEQEX / BNEEX: `alusrca`=1, SUB, `pcsrc`=01. `pcen` = `zero` in BEQEX, `~zero` in BNEEX.
- IMMEX: `alusrca`=1, `alusrcb`=10. Operation: ADD for ADDI, AND for ANDI, OR for ORI, SLT for SLTI. `zeroext`=1 for ANDI/ORI.
- IMMWB: `regwrite`=1, `regdst`=0. `zeroext` and `alucontrol` are held per `op`.
- JEX: `pcen`=1, `pcsrc`=10.
- TRAP: `illegal`=1, all enables 0.

**Other rules**
- An unknown `funct` in RTYPEEX gives `alucontrol`=010 and is not trapped.
- `instret` increments by 1 on every transition into FETCH from a non-FETCH state. It wraps modulo 2^`CNT_W`.
- All outputs are 0/defined; there are no X outputs in any state.

## Timing
- Moore state register. `pcen`, `irwrite` and the handshake exits are additionally combinational on `mem_ready` and `zero`.
- Zero-wait latencies (`mem_ready` held high):
  - LW 5 cycles; SW, R-type, immediate ops 4 cycles.
  - BEQ, BNE, J 3 cycles.
- Each cycle with `mem_ready` low in a memory state adds 1 cycle. `mem_req`, `iord` and `memwrite` stay stable while waiting.
- `MEM_HANDSHAKE`=0 gives the zero-wait latencies regardless of `mem_ready`.
- On `reset` assertion, mid-instruction included, the block asynchronously moves to FETCH and resets `instret` to 0 and `illegal` to 0.
- Values during reset (the FETCH outputs): `mem_req`=1, `alusrcb`=01, `alucontrol`=010; `pcen`=`irwrite`=0 because the enables are gated with ~`reset`; all other outputs 0.

## Structure
- Package `mc_pkg` holds:
  - the state enum `mc_state_t`,
  - opcode constants (`OP_LW`, `OP_SW`, `OP_RTYPE`, `OP_BEQ`, `OP_BNE`, `OP_ADDI`, `OP_ANDI`, `OP_ORI`, `OP_SLTI`, `OP_J`),
  - funct constants,
  - the `alucontrol` encodings (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`).
- One sub-module, `mc_aludec`: combinational mapping of (state class, `op`, `funct`) to `alucontrol`.
- The FSM, output decode and `instret` counter live in `mc_controller_p`.

## Test plan
- **Zero-wait instructions** (`mem_ready`=1): run `op`=100011 (LW), then `op`=000000 with `funct`=100010 (SUB).
  - LW: FETCH→DECODE→MEMADR→MEMRD→MEMWB→FETCH in 5 cycles.
  - SUB: RTYPEEX shows `alucontrol`=110; RTYPEWB shows `regwrite`=1, `regdst`=1.
  - `instret`=2 at the end.
- **Memory stall**: SW with `mem_ready` low for 3 cycles in MEMWR.
  - `memwrite`=1 and `iord`=1 for 4 consecutive cycles; state then goes to FETCH.
  - Total SW latency 7 cycles.
- **Branches**:
  - BEQ with `zero`=1 → `pcen`=1, `pcsrc`=01 in BEQEX.
  - BNE with `zero`=1 → `pcen`=0.
  - BNE with `zero`=0 → `pcen`=1.
- **Immediate ops**: ORI (`op`=001101) → IMMEX shows `alucontrol`=001, `zeroext`=1; IMMWB shows `regwrite`=1, `regdst`=0.
- **Illegal opcode and reset**:
  - `op`=111111 in DECODE → TRAP; `illegal`=1 and stays high for 10 cycles with `pcen`=`regwrite`=`memwrite`=0.
  - Asserting `reset` mid-cycle clears `illegal` and `instret` immediately and returns the FSM to FETCH.
- **Counter wrap**: with `CNT_W`=4, retire 17 J instructions (3 cycles each) → `instret`=1. Repeat with `MEM_HANDSHAKE`=0 while `mem_ready`=0: J still takes 3 cycles.
